// File: rtl/qerv_dbus_ctrl.sv
// qerv_dbus_ctrl -- data-bus controller between the core state logic and a
// single-master Wishbone-style bus (one combined cyc/stb signal).
//
// A one-cycle request from the core is checked for natural alignment. An
// aligned request opens one bus cycle. The block then waits in BUSY for
// i_wb_ack and reports completion with a one-cycle o_ack. Loads also return
// the data with a one-cycle o_load strobe. A misaligned request never reaches
// the bus. Instead it produces a one-cycle o_misalign pulse.
//
// Optional feature: define QERV_DBUS_TIMEOUT_EN to add a bus watchdog. It
// abandons a cycle that is still unacknowledged after TIMEOUT_CYCLES BUSY
// cycles and reports this with a one-cycle o_err pulse. Without the macro
// there is no counter, BUSY waits indefinitely and o_err is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  watchdog limit in clock cycles (2..65536)
// Ports
//   i_clk, i_rst          rising-edge clock, asynchronous active-high reset
//   i_req                 one-cycle request from core state
//   i_we, i_word, i_half  store/load and access size, sampled with i_req
//   i_addr, i_wdat        byte address and pre-aligned store data
//   o_wb_adr/dat/sel/we   registered bus request, stable while o_wb_cyc
//   o_wb_cyc              bus cycle / strobe
//   i_wb_rdt, i_wb_ack    bus read data and acknowledge
//   o_load, o_dat         load strobe and registered load data
//   o_ack                 completion pulse
//   o_misalign            misaligned-request pulse
//   o_err                 bus-timeout pulse
//   o_busy                high while a bus cycle is open

module qerv_dbus_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic        i_word,
  input  logic        i_half,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdat,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_load,
  output logic [31:0] o_dat,
  output logic        o_ack,
  output logic        o_misalign,
  output logic        o_err,
  output logic        o_busy
);

  // Reject out-of-range watchdog limits at elaboration time.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("qerv_dbus_ctrl: TIMEOUT_CYCLES must be in 2..65536");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Lane enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_sel(input logic       word,
                                          input logic       half,
                                          input logic [1:0] ofs);
    logic [3:0] sel;
    if (word)
      sel = 4'b1111;
    else if (half)
      sel = ofs[1] ? 4'b1100 : 4'b0011;
    else
      sel = 4'b0001 << ofs;
    return sel;
  endfunction

  // Natural alignment. Bytes are always aligned.
  function automatic logic is_aligned(input logic       word,
                                      input logic       half,
                                      input logic [1:0] ofs);
    logic ok;
    if (word)
      ok = (ofs == 2'b00);
    else if (half)
      ok = ~ofs[0];
    else
      ok = 1'b1;
    return ok;
  endfunction

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [31:0] adr_reg,   adr_next;
  logic [31:0] wdat_reg,  wdat_next;
  logic [3:0]  sel_reg,   sel_next;
  logic        we_reg,    we_next;
  logic [31:0] rdat_reg,  rdat_next;
  logic        load_reg,  load_next;
  logic        ack_reg,   ack_next;
  logic        mis_reg,   mis_next;

  logic        req_aligned;
  logic [3:0]  req_sel;

  assign req_aligned = is_aligned(i_word, i_half, i_addr[1:0]);
  assign req_sel     = lane_sel(i_word, i_half, i_addr[1:0]);

`ifdef QERV_DBUS_TIMEOUT_EN
  // The counter holds (BUSY cycles elapsed - 1). It expires during the
  // TIMEOUT_CYCLES-th BUSY cycle, so its largest value is TIMEOUT_CYCLES-1.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      adr_reg   <= '0;
      wdat_reg  <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      rdat_reg  <= '0;
      load_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      mis_reg   <= 1'b0;
`ifdef QERV_DBUS_TIMEOUT_EN
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      adr_reg   <= adr_next;
      wdat_reg  <= wdat_next;
      sel_reg   <= sel_next;
      we_reg    <= we_next;
      rdat_reg  <= rdat_next;
      load_reg  <= load_next;
      ack_reg   <= ack_next;
      mis_reg   <= mis_next;
`ifdef QERV_DBUS_TIMEOUT_EN
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    // Bus request fields hold by default so they stay stable through BUSY.
    // Pulse outputs default low.
    state_next = state_reg;
    adr_next   = adr_reg;
    wdat_next  = wdat_reg;
    sel_next   = sel_reg;
    we_next    = we_reg;
    rdat_next  = rdat_reg;
    load_next  = 1'b0;
    ack_next   = 1'b0;
    mis_next   = 1'b0;
`ifdef QERV_DBUS_TIMEOUT_EN
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
`endif

    unique case (state_reg)
      IDLE: begin
        // i_wb_ack is deliberately not looked at here.
        if (i_req) begin
          if (req_aligned) begin
            state_next = BUSY;
            adr_next   = {i_addr[31:2], 2'b00};
            wdat_next  = i_wdat;
            sel_next   = req_sel;
            we_next    = i_we;
`ifdef QERV_DBUS_TIMEOUT_EN
            cnt_next   = '0;
`endif
          end else begin
            mis_next = 1'b1;
          end
        end
      end

      BUSY: begin
        // i_req is ignored here; nothing is queued.
        if (i_wb_ack) begin
          // An ack in the expiry cycle still completes normally.
          state_next = IDLE;
          ack_next   = 1'b1;
          if (!we_reg) begin
            load_next = 1'b1;
            rdat_next = i_wb_rdt;
          end
        end
`ifdef QERV_DBUS_TIMEOUT_EN
        else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The bus cycle is exactly the BUSY state. Reset therefore drops it
  // without waiting for a clock edge.
  assign o_wb_cyc   = (state_reg == BUSY);
  assign o_busy     = (state_reg == BUSY);
  assign o_wb_adr   = adr_reg;
  assign o_wb_dat   = wdat_reg;
  assign o_wb_sel   = sel_reg;
  assign o_wb_we    = we_reg;
  assign o_dat      = rdat_reg;
  assign o_load     = load_reg;
  assign o_ack      = ack_reg;
  assign o_misalign = mis_reg;

`ifdef QERV_DBUS_TIMEOUT_EN
  assign o_err = err_reg;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_qerv_dbus_ctrl.sv
// Self-checking bench for qerv_dbus_ctrl: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_qerv_dbus_ctrl;

  localparam int TMO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req, i_we, i_word, i_half;
  logic [31:0] i_addr, i_wdat, i_wb_rdt;
  logic        i_wb_ack;
  logic [31:0] o_wb_adr, o_wb_dat, o_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc, o_load, o_ack, o_misalign, o_err, o_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: the most recent load data returned to the core.
  logic [31:0] model_dat;

  qerv_dbus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
    .i_word(i_word), .i_half(i_half), .i_addr(i_addr), .i_wdat(i_wdat),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .i_wb_rdt(i_wb_rdt),
    .i_wb_ack(i_wb_ack), .o_load(o_load), .o_dat(o_dat), .o_ack(o_ack),
    .o_misalign(o_misalign), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference rules: a size of 4, 2 or 1 bytes must start on a multiple of
  // that size. Its lanes are 'size' consecutive ones starting at the offset.
  function automatic int ref_size(input logic word, input logic half);
    return word ? 4 : (half ? 2 : 1);
  endfunction
  function automatic logic ref_aligned(input int size, input logic [31:0] a);
    return (a % size) == 0;
  endfunction
  function automatic logic [3:0] ref_sel(input int size, input logic [31:0] a);
    int ofs;
    ofs = a % 4;
    return 4'(((1 << size) - 1) << ofs);
  endfunction

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic drive_req(input logic we, input logic word, input logic half,
                           input logic [31:0] addr, input logic [31:0] wdat);
    i_req = 1'b1; i_we = we; i_word = word; i_half = half;
    i_addr = addr; i_wdat = wdat;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_we = 1'b0; i_word = 1'b0; i_half = 1'b0;
    i_addr = '0; i_wdat = '0; i_wb_ack = 1'b0; i_wb_rdt = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b1;
    tick(); tick();
    total_cnt++; if ({o_wb_cyc, o_wb_we, o_load, o_ack, o_misalign, o_err, o_busy} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0000000", {o_wb_cyc, o_wb_we, o_load, o_ack, o_misalign, o_err, o_busy}); else pass_cnt++;
    total_cnt++; if ({o_wb_adr, o_wb_dat, o_dat, o_wb_sel} !== 100'b0)
      $display("FAIL reset_data: got adr=%h dat=%h odat=%h sel=%b want zeros", o_wb_adr, o_wb_dat, o_dat, o_wb_sel); else pass_cnt++;
    // A request presented at release is taken on the very next edge.
    i_rst = 1'b0;
    drive_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    idle_inputs();
    total_cnt++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h40)
      $display("FAIL first_req: got cyc=%b adr=%h want cyc=1 adr=00000040", o_wb_cyc, o_wb_adr); else pass_cnt++;
    i_wb_ack = 1'b1; i_wb_rdt = 32'h1234_5678;
    tick();
    idle_inputs();
    model_dat = 32'h1234_5678;
    total_cnt++; if (o_ack !== 1'b1 || o_load !== 1'b1 || o_dat !== model_dat)
      $display("FAIL first_ack: got ack=%b load=%b dat=%h want 1 1 %h", o_ack, o_load, o_dat, model_dat); else pass_cnt++;
    tick();
    $display("txn reset+first load done");
  endtask

  task automatic test_load_word();
    drive_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    idle_inputs();
    total_cnt++; if (o_wb_cyc !== 1'b1 || o_wb_sel !== 4'b1111 || o_wb_adr !== 32'h100 || o_wb_we !== 1'b0)
      $display("FAIL load_word_req: got cyc=%b sel=%b adr=%h we=%b want 1 1111 00000100 0", o_wb_cyc, o_wb_sel, o_wb_adr, o_wb_we); else pass_cnt++;
    tick(); tick();
    i_wb_ack = 1'b1; i_wb_rdt = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    model_dat = 32'hDEAD_BEEF;
    total_cnt++; if (o_ack !== 1'b1 || o_load !== 1'b1 || o_dat !== 32'hDEAD_BEEF || o_wb_cyc !== 1'b0)
      $display("FAIL load_word_ack: got ack=%b load=%b dat=%h cyc=%b want 1 1 deadbeef 0", o_ack, o_load, o_dat, o_wb_cyc); else pass_cnt++;
    tick();
    total_cnt++; if (o_ack !== 1'b0 || o_load !== 1'b0 || o_dat !== 32'hDEAD_BEEF)
      $display("FAIL load_word_after: got ack=%b load=%b dat=%h want 0 0 deadbeef", o_ack, o_load, o_dat); else pass_cnt++;
    $display("txn load word 0x100 done");
  endtask

  task automatic test_store_byte();
    drive_req(1'b1, 1'b0, 1'b0, 32'h203, 32'hAA00_0000);
    tick();
    idle_inputs();
    total_cnt++; if (o_wb_sel !== 4'b1000 || o_wb_adr !== 32'h200 || o_wb_we !== 1'b1 || o_wb_dat !== 32'hAA00_0000)
      $display("FAIL store_byte_req: got sel=%b adr=%h we=%b dat=%h want 1000 00000200 1 aa000000", o_wb_sel, o_wb_adr, o_wb_we, o_wb_dat); else pass_cnt++;
    i_wb_ack = 1'b1; i_wb_rdt = 32'h5555_5555;
    tick();
    idle_inputs();
    total_cnt++; if (o_ack !== 1'b1 || o_load !== 1'b0 || o_dat !== model_dat)
      $display("FAIL store_byte_ack: got ack=%b load=%b dat=%h want 1 0 %h", o_ack, o_load, o_dat, model_dat); else pass_cnt++;
    tick();
    $display("txn store byte 0x203 done");
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [2];
    logic        words [2];
    addrs[0] = 32'h301; words[0] = 1'b0;
    addrs[1] = 32'h302; words[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_req(1'b0, words[k], ~words[k], addrs[k], 32'h0);
      tick();
      idle_inputs();
      total_cnt++; if (o_misalign !== 1'b1 || o_wb_cyc !== 1'b0 || o_ack !== 1'b0 || o_load !== 1'b0)
        $display("FAIL misalign_pulse[%0d]: got mis=%b cyc=%b ack=%b load=%b want 1 0 0 0", k, o_misalign, o_wb_cyc, o_ack, o_load); else pass_cnt++;
      tick();
      total_cnt++; if (o_misalign !== 1'b0 || o_wb_cyc !== 1'b0 || o_ack !== 1'b0)
        $display("FAIL misalign_after[%0d]: got mis=%b cyc=%b ack=%b want 0 0 0", k, o_misalign, o_wb_cyc, o_ack); else pass_cnt++;
      $display("txn misaligned %s at %h done", words[k] ? "word" : "half", addrs[k]);
    end
  endtask

  task automatic test_req_during_busy();
    int acks;
    acks = 0;
    drive_req(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
    tick();
    drive_req(1'b1, 1'b0, 1'b0, 32'h601, 32'hFFFF_FFFF);
    tick();
    idle_inputs();
    total_cnt++; if (o_wb_adr !== 32'h500 || o_wb_we !== 1'b0 || o_wb_cyc !== 1'b1)
      $display("FAIL busy_req_ignored: got adr=%h we=%b cyc=%b want 00000500 0 1", o_wb_adr, o_wb_we, o_wb_cyc); else pass_cnt++;
    i_wb_ack = 1'b1; i_wb_rdt = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    model_dat = 32'h0BAD_F00D;
    for (int c = 0; c < 5; c++) begin
      if (o_ack === 1'b1) acks++;
      tick();
    end
    total_cnt++; if (acks != 1 || o_wb_cyc !== 1'b0 || o_dat !== model_dat)
      $display("FAIL busy_req_one_ack: got acks=%0d cyc=%b dat=%h want 1 0 %h", acks, o_wb_cyc, o_dat, model_dat); else pass_cnt++;
    $display("txn request during busy done");
  endtask

  task automatic test_ack_while_idle();
    i_wb_ack = 1'b1; i_wb_rdt = 32'hCAFE_0000;
    tick(); tick();
    idle_inputs();
    total_cnt++; if (o_ack !== 1'b0 || o_load !== 1'b0 || o_dat !== model_dat || o_wb_cyc !== 1'b0)
      $display("FAIL idle_ack: got ack=%b load=%b dat=%h cyc=%b want 0 0 %h 0", o_ack, o_load, o_dat, o_wb_cyc, model_dat); else pass_cnt++;
    $display("txn ack while idle done");
  endtask

  task automatic test_reset_mid_busy();
    int acks;
    acks = 0;
    drive_req(1'b0, 1'b1, 1'b0, 32'h700, 32'h0);
    tick();
    idle_inputs();
    #2 i_rst = 1'b1;
    #1;
    total_cnt++; if (o_wb_cyc !== 1'b0 || o_busy !== 1'b0 || o_dat !== 32'h0)
      $display("FAIL async_reset: got cyc=%b busy=%b dat=%h want 0 0 00000000", o_wb_cyc, o_busy, o_dat); else pass_cnt++;
    model_dat = 32'h0;
    tick();
    i_rst = 1'b0;
    i_wb_ack = 1'b1; i_wb_rdt = 32'h7777_7777;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      if (o_ack === 1'b1 || o_load === 1'b1) acks++;
      tick();
    end
    total_cnt++; if (acks != 0 || o_dat !== 32'h0)
      $display("FAIL late_ack_ignored: got acks=%0d dat=%h want 0 00000000", acks, o_dat); else pass_cnt++;
    $display("txn reset during busy done");
  endtask

  task automatic test_timeout();
    // No ack at all.
    drive_req(1'b0, 1'b1, 1'b0, 32'h800, 32'h0);
    tick();
    idle_inputs();
`ifdef QERV_DBUS_TIMEOUT_EN
    for (int c = 1; c <= TMO; c++) begin
      total_cnt++; if (o_wb_cyc !== 1'b1 || o_err !== 1'b0)
        $display("FAIL timeout_wait[%0d]: got cyc=%b err=%b want 1 0", c, o_wb_cyc, o_err); else pass_cnt++;
      tick();
    end
    total_cnt++; if (o_err !== 1'b1 || o_wb_cyc !== 1'b0 || o_ack !== 1'b0 || o_load !== 1'b0)
      $display("FAIL timeout_err: got err=%b cyc=%b ack=%b load=%b want 1 0 0 0", o_err, o_wb_cyc, o_ack, o_load); else pass_cnt++;
    tick();
    total_cnt++; if (o_err !== 1'b0)
      $display("FAIL timeout_err_once: got err=%b want 0", o_err); else pass_cnt++;
    // Ack in the expiry cycle wins.
    drive_req(1'b0, 1'b1, 1'b0, 32'h804, 32'h0);
    tick();
    idle_inputs();
    for (int c = 1; c < TMO; c++) tick();
    i_wb_ack = 1'b1; i_wb_rdt = 32'h4444_4444;
    tick();
    idle_inputs();
    model_dat = 32'h4444_4444;
    total_cnt++; if (o_ack !== 1'b1 || o_err !== 1'b0 || o_dat !== model_dat)
      $display("FAIL timeout_ack_wins: got ack=%b err=%b dat=%h want 1 0 %h", o_ack, o_err, o_dat, model_dat); else pass_cnt++;
    tick();
    total_cnt++; if (o_err !== 1'b0)
      $display("FAIL timeout_no_late_err: got err=%b want 0", o_err); else pass_cnt++;
`else
    // Without the watchdog the cycle is held far past any limit.
    for (int c = 0; c < 20; c++) tick();
    total_cnt++; if (o_wb_cyc !== 1'b1 || o_err !== 1'b0)
      $display("FAIL no_timeout_hold: got cyc=%b err=%b want 1 0", o_wb_cyc, o_err); else pass_cnt++;
    i_wb_ack = 1'b1; i_wb_rdt = 32'h4444_4444;
    tick();
    idle_inputs();
    model_dat = 32'h4444_4444;
    total_cnt++; if (o_ack !== 1'b1 || o_err !== 1'b0 || o_dat !== model_dat)
      $display("FAIL no_timeout_ack: got ack=%b err=%b dat=%h want 1 0 %h", o_ack, o_err, o_dat, model_dat); else pass_cnt++;
    tick();
`endif
    $display("txn timeout scenario done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic        we, word, half;
      logic [31:0] addr, wdat, rdt;
      int          size, dly;
      logic [3:0]  exp_sel;
      we   = 1'($urandom_range(0, 1));
      size = 1 << $urandom_range(0, 2);
      word = (size == 4);
      half = (size == 2);
      addr = $urandom;
      wdat = $urandom;
      rdt  = $urandom;
      dly  = $urandom_range(0, 3);
      drive_req(we, word, half, addr, wdat);
      tick();
      idle_inputs();
      if (!ref_aligned(size, addr)) begin
        total_cnt++; if (o_misalign !== 1'b1 || o_wb_cyc !== 1'b0 || o_ack !== 1'b0)
          $display("FAIL rnd_misalign[%0d]: got mis=%b cyc=%b ack=%b want 1 0 0", n, o_misalign, o_wb_cyc, o_ack); else pass_cnt++;
        tick();
        $display("txn %0d misaligned size=%0d addr=%h", n, size, addr);
        continue;
      end
      exp_sel = ref_sel(size, addr);
      total_cnt++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== (addr & 32'hFFFF_FFFC) || o_wb_sel !== exp_sel || o_wb_we !== we || o_wb_dat !== wdat || o_misalign !== 1'b0)
        $display("FAIL rnd_req[%0d]: got cyc=%b adr=%h sel=%b we=%b dat=%h want 1 %h %b %b %h", n, o_wb_cyc, o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, addr & 32'hFFFF_FFFC, exp_sel, we, wdat); else pass_cnt++;
      for (int d = 0; d < dly; d++) begin
        // Stray requests while busy must not disturb the open cycle.
        i_req = 1'($urandom_range(0, 1)); i_addr = $urandom; i_wdat = $urandom; i_we = ~we;
        tick();
        idle_inputs();
        total_cnt++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== (addr & 32'hFFFF_FFFC) || o_wb_sel !== exp_sel || o_wb_dat !== wdat || o_ack !== 1'b0)
          $display("FAIL rnd_stable[%0d]: got cyc=%b adr=%h sel=%b dat=%h ack=%b", n, o_wb_cyc, o_wb_adr, o_wb_sel, o_wb_dat, o_ack); else pass_cnt++;
      end
      i_wb_ack = 1'b1; i_wb_rdt = rdt;
      tick();
      idle_inputs();
      if (!we) model_dat = rdt;
      total_cnt++; if (o_ack !== 1'b1 || o_load !== !we || o_dat !== model_dat || o_wb_cyc !== 1'b0 || o_err !== 1'b0)
        $display("FAIL rnd_ack[%0d]: got ack=%b load=%b dat=%h cyc=%b err=%b want 1 %b %h 0 0", n, o_ack, o_load, o_dat, o_wb_cyc, o_err, !we, model_dat); else pass_cnt++;
      tick();
      $display("txn %0d %s size=%0d addr=%h sel=%b", n, we ? "store" : "load", size, addr, exp_sel);
    end
  endtask

  initial begin
    model_dat = '0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_misalign();
    test_req_during_busy();
    test_ack_while_idle();
    test_reset_mid_busy();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
